// File: rtl/ne16_input_buffer_loader.sv
// Write-side controller for the NE16 input buffer: streams words in, inserts
// zero padding, supports broadcast, and hands a full tile to the engine.
module ne16_input_buffer_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] nb_words_i,
  input  logic [NUM_WORDS-1:0]  pad_mask_i,
  input  logic                  bcast_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  we_o,
  output logic                  we_all_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  clear_o,
  output logic                  buf_valid_o,
  input  logic                  buf_release_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_nb, w_nb_nxt, w_nb_clamp;
  logic [NUM_WORDS-1:0]  r_pad, w_pad_nxt, w_pad_sh;
  logic                  r_bcast, w_bcast_nxt;
  logic                  w_is_pad, w_advance;

  assign w_nb_clamp = (nb_words_i > LAST) ? LAST : nb_words_i;
  assign w_pad_sh   = r_pad >> r_cnt;
  assign w_is_pad   = w_pad_sh[0] & ~r_bcast;

  assign waddr_o = r_cnt;
  assign clear_o = clear_i;
  assign busy_o  = (r_state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_nb    <= '0;
      r_pad   <= '0;
      r_bcast <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_nb    <= w_nb_nxt;
      r_pad   <= w_pad_nxt;
      r_bcast <= w_bcast_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_nb_nxt    = r_nb;
    w_pad_nxt   = r_pad;
    w_bcast_nxt = r_bcast;
    w_advance   = 1'b0;
    in_ready_o  = 1'b0;
    we_o        = 1'b0;
    we_all_o    = 1'b0;
    wdata_o     = in_data_i;
    buf_valid_o = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_nb_nxt    = w_nb_clamp;
          w_pad_nxt   = pad_mask_i;
          w_bcast_nxt = bcast_i;
          w_cnt_nxt   = '0;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (r_bcast) begin
          // Ready is unconditional here, so valid alone marks a transfer.
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            we_o        = 1'b1;
            we_all_o    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = FULL;
          end
        end else if (w_is_pad) begin
          we_o      = 1'b1;
          wdata_o   = '0;
          w_advance = 1'b1;
        end else begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            we_o      = 1'b1;
            w_advance = 1'b1;
          end
        end
        if (w_advance) begin
          if (r_cnt == r_nb) begin
            w_cnt_nxt   = '0;
            w_state_nxt = FULL;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        buf_valid_o = 1'b1;
        if (buf_release_i) begin
          if (start_i) begin
            w_nb_nxt    = w_nb_clamp;
            w_pad_nxt   = pad_mask_i;
            w_bcast_nxt = bcast_i;
            w_cnt_nxt   = '0;
            w_state_nxt = LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (clear_i) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_nb_nxt    = '0;
      w_pad_nxt   = '0;
      w_bcast_nxt = 1'b0;
      in_ready_o  = 1'b0;
      we_o        = 1'b0;
      we_all_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ne16_input_buffer_loader.sv
// Scoreboard bench: expected buffer writes are queued per tile, a negedge
// monitor pops and compares every write the loader issues.
module tb_ne16_input_buffer_loader;
  localparam int AW = 5, DW = 128, NW = 25;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          clear_i = 0, start_i = 0, bcast_i = 0, in_valid_i = 0, buf_release_i = 0;
  logic [AW-1:0] nb_words_i = '0;
  logic [NW-1:0] pad_mask_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_ready_o, we_o, we_all_o, clear_o, buf_valid_o, busy_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;

  ne16_input_buffer_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .nb_words_i(nb_words_i), .pad_mask_i(pad_mask_i), .bcast_i(bcast_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .we_o(we_o), .we_all_o(we_all_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .clear_o(clear_o), .buf_valid_o(buf_valid_o), .buf_release_i(buf_release_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          all;
    logic          rdy;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk_i) begin
    if (rst_ni && we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1'b1, 1'b0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", DW'(waddr_o), DW'(e.addr));
        check("wdata", wdata_o, e.data);
        check("we_all", DW'(we_all_o), DW'(e.all));
        check("ready_at_write", DW'(in_ready_o), DW'(e.rdy));
        if (in_ready_o) check("write_without_valid", DW'(in_valid_i), DW'(1));
      end
    end
  end

  function automatic logic vpat(input int mode, input int cyc);
    case (mode)
      1:       return ((cyc - 1) % 3) == 0;
      2:       return cyc >= 4;
      default: return 1'b1;
    endcase
  endfunction

  // Queues the expected writes, starts a tile, streams beats until FULL.
  task automatic load_tile(input string name, input int nb, input logic [NW-1:0] pad,
                           input logic bc, input logic [DW-1:0] base, input int mode,
                           input logic b2b, input int exp_beats, input int exp_full);
    int  last, bi, cyc, full;
    logic fire;
    wr_t e;
    last = (nb > NW - 1) ? NW - 1 : nb;
    bi = 0;
    if (bc) begin
      e.addr = '0; e.data = base; e.all = 1'b1; e.rdy = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k <= last; k++) begin
        e.addr = AW'(k); e.all = 1'b0;
        if (pad[k]) begin e.data = '0; e.rdy = 1'b0; end
        else begin e.data = base + DW'(bi); e.rdy = 1'b1; bi++; end
        exp_q.push_back(e);
      end
    end
    nb_words_i = AW'(nb); pad_mask_i = pad; bcast_i = bc;
    start_i = 1'b1; buf_release_i = b2b;
    @(posedge clk_i); #1;
    start_i = 1'b0; buf_release_i = 1'b0;
    cyc = 1; bi = 0; full = 0;
    if (b2b) begin
      check({name, "_b2b_bufvalid"}, DW'(buf_valid_o), DW'(0));
      check({name, "_b2b_busy"}, DW'(busy_o), DW'(1));
      check({name, "_b2b_cnt"}, DW'(waddr_o), DW'(0));
      check({name, "_b2b_ready"}, DW'(in_ready_o), DW'(1));
    end
    while (cyc < 200) begin
      if (buf_valid_o) begin full = cyc; break; end
      in_valid_i = vpat(mode, cyc);
      in_data_i  = in_valid_i ? base + DW'(bi) : {4{32'hDEADBEEF}};
      @(negedge clk_i);
      fire = in_valid_i & in_ready_o;
      @(posedge clk_i); #1;
      cyc++;
      if (fire) bi++;
    end
    in_valid_i = 1'b0;
    check({name, "_full_cycle"}, DW'(full), DW'(exp_full));
    check({name, "_beats"}, DW'(bi), DW'(exp_beats));
    check({name, "_queue_drained"}, DW'(exp_q.size()), DW'(0));
    exp_q.delete();
  endtask

  task automatic release_buf();
    buf_release_i = 1'b1;
    @(posedge clk_i); #1;
    buf_release_i = 1'b0;
    check("release_bufvalid", DW'(buf_valid_o), DW'(0));
    check("release_busy", DW'(busy_o), DW'(0));
  endtask

  initial begin
    wr_t e;
    #12;
    check("rst_we", DW'(we_o), DW'(0));
    check("rst_we_all", DW'(we_all_o), DW'(0));
    check("rst_ready", DW'(in_ready_o), DW'(0));
    check("rst_bufvalid", DW'(buf_valid_o), DW'(0));
    check("rst_busy", DW'(busy_o), DW'(0));
    check("rst_waddr", DW'(waddr_o), DW'(0));
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    load_tile("plain", 24, '0, 1'b0, '0, 0, 1'b0, 25, 26);
    release_buf();
    load_tile("pad", 8, NW'('h111), 1'b0, DW'('h100), 0, 1'b0, 6, 10);

    // start while FULL without release is dropped
    nb_words_i = AW'(2); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("full_start_bufvalid", DW'(buf_valid_o), DW'(1));
    check("full_start_ready", DW'(in_ready_o), DW'(0));
    @(posedge clk_i); #1;
    check("full_start_hold", DW'(buf_valid_o), DW'(1));

    load_tile("b2b", 3, '0, 1'b0, DW'('h200), 0, 1'b1, 4, 5);
    release_buf();
    load_tile("bp", 3, '0, 1'b0, DW'('h400), 1, 1'b0, 4, 11);
    release_buf();
    load_tile("bcast", 0, NW'(1), 1'b1, {16{8'hA5}}, 2, 1'b0, 1, 5);
    release_buf();
    load_tile("clamp", 31, '0, 1'b0, DW'('h500), 0, 1'b0, 25, 26);
    release_buf();

    // clear in the middle of a 10-word tile, together with start
    for (int k = 0; k < 5; k++) begin
      e.addr = AW'(k); e.data = DW'('h300 + k); e.all = 1'b0; e.rdy = 1'b1;
      exp_q.push_back(e);
    end
    nb_words_i = AW'(9); pad_mask_i = '0; bcast_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid_i = 1'b1; in_data_i = DW'('h300 + k);
      @(posedge clk_i); #1;
    end
    clear_i = 1'b1; start_i = 1'b1; in_data_i = DW'('h305);
    @(negedge clk_i);
    check("clr_clear_o", DW'(clear_o), DW'(1));
    check("clr_we", DW'(we_o), DW'(0));
    check("clr_ready", DW'(in_ready_o), DW'(0));
    @(posedge clk_i); #1;
    clear_i = 1'b0; start_i = 1'b0;
    check("clr_busy", DW'(busy_o), DW'(0));
    check("clr_bufvalid", DW'(buf_valid_o), DW'(0));
    check("clr_clear_o_low", DW'(clear_o), DW'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("clr_idle_ready", DW'(in_ready_o), DW'(0));
    end
    in_valid_i = 1'b0;
    check("clr_queue_drained", DW'(exp_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ne16_input_buffer_loader.md
Name: ne16_input_buffer_loader

Overview:
Write-side controller for the NE16 latch-based input buffer.
- Accepts a valid/ready stream of DATA_WIDTH-bit words from the input streamer.
- Drives the buffer write port (we, we_all, waddr, wdata, clear).
- Inserts zero words at padded positions.
- Signals a full buffer to the engine and waits for its release before loading the next tile.

Parameters:
ADDR_WIDTH, 5, width of word address and word-count fields
DATA_WIDTH, 128, width of one buffer word
NUM_WORDS, 25, number of buffer words (NUM_WORDS <= 2**ADDR_WIDTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous soft clear, highest priority
start_i  in  1  single-cycle pulse; begin loading a tile
nb_words_i  in  ADDR_WIDTH  number of words to load minus 1; sampled on accepted start
pad_mask_i  in  NUM_WORDS  bit k=1: word k is zero padding; sampled on accepted start
bcast_i  in  1  broadcast mode: one stream beat written to all words; sampled on accepted start
in_valid_i  in  1  stream valid
in_ready_o  out  1  stream ready
in_data_i  in  DATA_WIDTH  stream data
we_o  out  1  buffer write enable
we_all_o  out  1  buffer write-all enable
waddr_o  out  ADDR_WIDTH  buffer write address
wdata_o  out  DATA_WIDTH  buffer write data
clear_o  out  1  buffer clear
buf_valid_o  out  1  buffer holds a complete tile
buf_release_i  in  1  engine has consumed the tile
busy_o  out  1  state != IDLE

Behaviour:
- Reset state: IDLE; cnt=0; config registers 0. All outputs 0.
- Registers:
  - cnt: ADDR_WIDTH bits.
  - nb_q: sampled nb_words_i, clamped to NUM_WORDS-1 if larger.
  - pad_q: sampled pad_mask_i.
  - bcast_q: sampled bcast_i.
- waddr_o = cnt in all states.
- wdata_o = in_data_i, or 0 when writing a pad word; combinational. The buffer samples it internally.
- in_ready_o depends only on state, cnt, pad_q and bcast_q, never on in_valid_i. No combinational valid->ready path.
- A stream beat transfers when in_valid_i & in_ready_o.
- FSM:
  - IDLE:
    - in_ready_o=0, we_o=0.
    - start_i: sample config, cnt<=0, go to LOAD.
  - LOAD, bcast_q=1:
    - in_ready_o=1.
    - On transfer: we_o=1, we_all_o=1, waddr_o=0; go to FULL. pad_q is ignored.
  - LOAD, bcast_q=0, pad_q[cnt]=1:
    - in_ready_o=0, we_o=1, wdata_o=0; advance. One word per cycle, no stream beat consumed.
  - LOAD, bcast_q=0, pad_q[cnt]=0:
    - in_ready_o=1.
    - On transfer: we_o=1, wdata_o=in_data_i; advance.
    - No transfer: hold cnt, we_o=0.
  - Advance:
    - cnt==nb_q: cnt<=0, go to FULL.
    - Otherwise cnt<=cnt+1.
  - FULL:
    - buf_valid_o=1, in_ready_o=0, we_o=0.
    - buf_release_i alone: go to IDLE.
    - buf_release_i & start_i in the same cycle: sample new config, cnt<=0, go directly to LOAD (back-to-back tiles).
- start_i in LOAD, or in FULL without buf_release_i, is ignored.
- buf_release_i outside FULL is ignored.
- Timing:
  - buf_valid_o rises the cycle after the last write. The buffer word is updated during the write cycle, so data is stable when buf_valid_o=1.
  - Latency with continuous in_valid_i and no padding: start at cycle 0, writes in cycles 1..nb+1, buf_valid_o from cycle nb+2.
  - Pad words take one cycle each.
- clear_i, overriding everything:
  - clear_o=clear_i (combinational).
  - we_o=0, we_all_o=0, in_ready_o=0 during clear.
  - Next state IDLE, cnt<=0, config registers <=0.
  - clear_i together with start_i: clear wins, start is dropped.
- Reset mid-LOAD: asynchronous return to IDLE. Partially written words are not guaranteed; the engine must not use them.
- Beats beyond nb+1 are never accepted; ready is 0 outside LOAD.

Test Plan:
- Plain load: nb_words_i=24, pad=0, in_valid held high, data=word index. Required: 25 writes at waddr 0..24 in consecutive cycles; buf_valid_o at cycle 26 after start; buffer word k = k.
- Padding: nb_words_i=8, pad_mask=0x111 (words 0,4,8). Required: words 0, 4 and 8 written 0 with in_ready_o=0 in those cycles; 6 beats consumed; buf_valid_o after 9 write cycles.
- Backpressure: in_valid toggled 1,0,0,1,… with nb=3. Required: cnt holds while in_valid=0; exactly 4 writes; no write with we_o=1 while in_valid=0 on a non-pad word.
- Broadcast: bcast_i=1, single beat 0xA5.., valid delayed 3 cycles. Required: one cycle with we_o=we_all_o=1; then FULL; all 25 words = 0xA5...
- Back-to-back: in FULL, assert buf_release_i and start_i together. Required: next cycle state LOAD, cnt=0, buf_valid_o=0. Separately, start_i in FULL without release is ignored.
- Clear mid-LOAD: after 5 of 10 words, pulse clear_i with start_i. Required: clear_o=1 that cycle, we_o=0; state IDLE; busy_o=0; no further writes until a new start.
